// File: rtl/noc_pkg.sv
// Shared mesh NoC definitions: output port indices, input-buffer FSM states
// and helpers for header field widths and direction one-hot encoding.
package noc_pkg;

    localparam int NUM_PORTS = 5;

    typedef enum logic [2:0] {
        PORT_HOME  = 3'd0,
        PORT_NORTH = 3'd1,
        PORT_EAST  = 3'd2,
        PORT_SOUTH = 3'd3,
        PORT_WEST  = 3'd4
    } port_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_FWD  = 2'd2,
        ST_DROP = 2'd3
    } ibuf_state_e;

    // A one-router dimension still needs a 1-bit field so slices stay legal.
    function automatic int field_width(input int extent);
        return (extent > 1) ? $clog2(extent) : 1;
    endfunction

    function automatic logic [NUM_PORTS-1:0] dir_to_onehot(input port_e dir);
        logic [NUM_PORTS-1:0] oh;
        oh = 5'b00000;
        case (dir)
            PORT_HOME:  oh = 5'b00001;
            PORT_NORTH: oh = 5'b00010;
            PORT_EAST:  oh = 5'b00100;
            PORT_SOUTH: oh = 5'b01000;
            PORT_WEST:  oh = 5'b10000;
            default:    oh = 5'b00000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/axis_sync_fifo.sv
// Single-clock flit FIFO with async active-low reset; the extra pointer MSB
// distinguishes full from empty. Overflowing pushes and empty pops are ignored.
module axis_sync_fifo #(
    parameter int WIDTH = 49,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_INC = {{AW{1'b0}}, 1'b1};

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic             push_s;
    logic             pop_s;

    assign full   = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty  = (wr_ptr_r == rd_ptr_r);
    assign push_s = push && !full;
    assign pop_s  = pop && !empty;
    assign rdata  = mem_r[rd_ptr_r[AW-1:0]];

    // Read/write pointer update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {(AW+1){1'b0}};
            rd_ptr_r <= {(AW+1){1'b0}};
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_INC;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_INC;
            end
        end
    end

    // Storage write; contents are don't-care until a pointer covers them.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[wr_ptr_r[AW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/axis_xy_input_buffer.sv
// Router input stage: buffers AXIS flits, XY-routes each head flit, requests
// the output from the allocator and streams the packet once granted.
module axis_xy_input_buffer
    import noc_pkg::*;
#(
    parameter int DATA_WIDTH    = 40,
    parameter int ID_WIDTH      = 3,
    parameter int DEPTH         = 4,
    parameter int ROUTER_X      = 0,
    parameter int ROUTER_Y      = 0,
    parameter int MAX_ROUTERS_X = 4,
    parameter int MAX_ROUTERS_Y = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_TVALID,
    output logic                    s_TREADY,
    input  logic [DATA_WIDTH-1:0]   s_TDATA,
    input  logic [ID_WIDTH-1:0]     s_TID,
    input  logic [DATA_WIDTH/8-1:0] s_TSTRB,
    input  logic                    s_TLAST,
    output logic                    m_TVALID,
    input  logic                    m_TREADY,
    output logic [DATA_WIDTH-1:0]   m_TDATA,
    output logic [ID_WIDTH-1:0]     m_TID,
    output logic [DATA_WIDTH/8-1:0] m_TSTRB,
    output logic                    m_TLAST,
    output logic [NUM_PORTS-1:0]    route_req,
    input  logic                    route_gnt,
    output logic                    drop
);

    localparam int X_W    = field_width(MAX_ROUTERS_X);
    localparam int Y_W    = field_width(MAX_ROUTERS_Y);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int PAY_W  = DATA_WIDTH + ID_WIDTH + STRB_W + 1;

    ibuf_state_e           state_r, state_s;
    logic [NUM_PORTS-1:0]  route_req_r, route_req_s;
    logic                  drop_r, drop_s;
    logic                  rdy_r;
    logic                  push_s, pop_s, full_s, empty_s, fwd_valid_s;
    logic [PAY_W-1:0]      head_s;
    logic [DATA_WIDTH-1:0] head_data_s;
    logic                  head_last_s;
    logic [X_W-1:0]        dst_x_s;
    logic [Y_W-1:0]        dst_y_s;
    logic                  out_of_mesh_s;
    port_e                 route_dir_s;

    assign s_TREADY = rdy_r && !full_s;
    assign push_s   = s_TVALID && s_TREADY;

    axis_sync_fifo #(
        .WIDTH (PAY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push_s),
        .wdata ({s_TDATA, s_TID, s_TSTRB, s_TLAST}),
        .full  (full_s),
        .pop   (pop_s),
        .rdata (head_s),
        .empty (empty_s)
    );

    assign {m_TDATA, m_TID, m_TSTRB, m_TLAST} = head_s;
    assign head_data_s = head_s[PAY_W-1 -: DATA_WIDTH];
    assign head_last_s = head_s[0];
    assign dst_x_s     = head_data_s[X_W-1:0];
    assign dst_y_s     = head_data_s[X_W+Y_W-1:X_W];

    // XY dimension-order decode of the FIFO head; X is resolved before Y.
    always_comb begin
        route_dir_s   = PORT_HOME;
        out_of_mesh_s = (int'(dst_x_s) >= MAX_ROUTERS_X) || (int'(dst_y_s) >= MAX_ROUTERS_Y);
        if (int'(dst_x_s) > ROUTER_X) begin
            route_dir_s = PORT_EAST;
        end else if (int'(dst_x_s) < ROUTER_X) begin
            route_dir_s = PORT_WEST;
        end else if (int'(dst_y_s) > ROUTER_Y) begin
            route_dir_s = PORT_SOUTH;
        end else if (int'(dst_y_s) < ROUTER_Y) begin
            route_dir_s = PORT_NORTH;
        end else begin
            route_dir_s = PORT_HOME;
        end
    end

    // Packet FSM: next state, pop, route request and drop pulse.
    always_comb begin
        state_s     = state_r;
        route_req_s = route_req_r;
        drop_s      = 1'b0;
        pop_s       = 1'b0;
        fwd_valid_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (empty_s) begin
                    state_s = ST_IDLE;
                end else if (out_of_mesh_s) begin
                    state_s = ST_DROP;
                end else begin
                    state_s     = ST_REQ;
                    route_req_s = dir_to_onehot(route_dir_s);
                end
            end
            ST_REQ: begin
                if (route_gnt) begin
                    state_s = ST_FWD;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_FWD: begin
                fwd_valid_s = !empty_s;
                if (fwd_valid_s && m_TREADY) begin
                    pop_s = 1'b1;
                    if (head_last_s) begin
                        state_s     = ST_IDLE;
                        route_req_s = {NUM_PORTS{1'b0}};
                    end else begin
                        state_s = ST_FWD;
                    end
                end else begin
                    state_s = ST_FWD;
                end
            end
            ST_DROP: begin
                if (!empty_s) begin
                    pop_s = 1'b1;
                    if (head_last_s) begin
                        state_s = ST_IDLE;
                        drop_s  = 1'b1;
                    end else begin
                        state_s = ST_DROP;
                    end
                end else begin
                    state_s = ST_DROP;
                end
            end
            default: begin
                state_s     = ST_IDLE;
                route_req_s = {NUM_PORTS{1'b0}};
            end
        endcase
    end

    // State and output registers; rdy_r keeps the upstream stalled while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            route_req_r <= {NUM_PORTS{1'b0}};
            drop_r      <= 1'b0;
            rdy_r       <= 1'b0;
        end else begin
            state_r     <= state_s;
            route_req_r <= route_req_s;
            drop_r      <= drop_s;
            rdy_r       <= 1'b1;
        end
    end

    assign m_TVALID  = fwd_valid_s;
    assign route_req = route_req_r;
    assign drop      = drop_r;

endmodule

// File: tb/tb_axis_xy_input_buffer.sv
// Directed bench for axis_xy_input_buffer at router (1,1) in a 5x4 mesh
// (3-bit X field); forwarded beats are checked against a flit scoreboard.
module tb_axis_xy_input_buffer;

    localparam logic [4:0] R_HOME  = 5'b00001;
    localparam logic [4:0] R_NORTH = 5'b00010;
    localparam logic [4:0] R_EAST  = 5'b00100;
    localparam logic [4:0] R_SOUTH = 5'b01000;
    localparam logic [4:0] R_WEST  = 5'b10000;
    localparam logic [4:0] R_NONE  = 5'b00000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_TVALID, s_TREADY, s_TLAST;
    logic [39:0] s_TDATA;
    logic [2:0]  s_TID;
    logic [4:0]  s_TSTRB;
    logic        m_TVALID, m_TREADY, m_TLAST;
    logic [39:0] m_TDATA;
    logic [2:0]  m_TID;
    logic [4:0]  m_TSTRB;
    logic [4:0]  route_req;
    logic        route_gnt;
    logic        drop;

    int errors = 0;
    int checks = 0;
    int beats  = 0;
    int drops  = 0;
    logic [48:0] exp_q [$];

    axis_xy_input_buffer #(
        .DATA_WIDTH(40), .ID_WIDTH(3), .DEPTH(4), .ROUTER_X(1), .ROUTER_Y(1),
        .MAX_ROUTERS_X(5), .MAX_ROUTERS_Y(4)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_TVALID(s_TVALID), .s_TREADY(s_TREADY), .s_TDATA(s_TDATA),
        .s_TID(s_TID), .s_TSTRB(s_TSTRB), .s_TLAST(s_TLAST),
        .m_TVALID(m_TVALID), .m_TREADY(m_TREADY), .m_TDATA(m_TDATA),
        .m_TID(m_TID), .m_TSTRB(m_TSTRB), .m_TLAST(m_TLAST),
        .route_req(route_req), .route_gnt(route_gnt), .drop(drop)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [39:0] mk_head(input logic [2:0] x, input logic [1:0] y);
        logic [34:0] upper;
        upper = 35'($urandom);
        return {upper, y, x};
    endfunction

    task automatic send(input logic [39:0] d, input logic last, input bit keep);
        logic [2:0] id;
        logic [4:0] st;
        bit ok;
        bit done;
        id = 3'($urandom_range(0, 7));
        st = 5'($urandom_range(0, 31));
        s_TVALID = 1'b1; s_TDATA = d; s_TID = id; s_TSTRB = st; s_TLAST = last;
        done = 1'b0;
        for (int i = 0; i < 40 && !done; i++) begin
            ok = s_TREADY;
            tick();
            if (ok) done = 1'b1;
        end
        s_TVALID = 1'b0;
        check("send_accept", 64'(done), 64'(1'b1));
        if (done && keep) exp_q.push_back({d, id, st, last});
    endtask

    task automatic grant();
        route_gnt = 1'b1;
        tick();
        route_gnt = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 40 && exp_q.size() != 0; i++) tick();
        check(tag, 64'(exp_q.size()), 64'(0));
    endtask

    task automatic wait_req(input string tag, input logic [4:0] want);
        for (int i = 0; i < 40 && route_req !== want; i++) tick();
        check(tag, 64'(route_req), 64'(want));
    endtask

    // Scoreboard: every forwarded beat must match the oldest expected flit.
    always @(negedge clk) begin
        if (rst_n && m_TVALID && m_TREADY) begin
            beats++;
            checks++;
            assert (exp_q.size() != 0) else begin
                errors++;
                $error("FAIL beat_unexpected: observed=%0h expected=none", {m_TDATA, m_TID, m_TSTRB, m_TLAST});
            end
            if (exp_q.size() != 0) begin
                check("beat_payload", 64'({m_TDATA, m_TID, m_TSTRB, m_TLAST}), 64'(exp_q.pop_front()));
            end
        end
        if (rst_n && drop) drops++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int drops0;
        bit bad;
        rst_n = 1'b0; s_TVALID = 1'b0; s_TDATA = 40'h0; s_TID = 3'h0; s_TSTRB = 5'h0;
        s_TLAST = 1'b0; m_TREADY = 1'b1; route_gnt = 1'b0;
        tick(); tick();
        check("rst_tready", 64'(s_TREADY), 64'(1'b0));
        check("rst_tvalid", 64'(m_TVALID), 64'(1'b0));
        check("rst_req", 64'(route_req), 64'(R_NONE));
        check("rst_drop", 64'(drop), 64'(1'b0));
        rst_n = 1'b1;
        #1;
        check("rel_tready_before_clk", 64'(s_TREADY), 64'(1'b0));
        tick();
        check("rel_tready_after_clk", 64'(s_TREADY), 64'(1'b1));

        // 3-flit packet to (3,1): EAST, route_req at N+2.
        send(mk_head(3'd3, 2'd1), 1'b0, 1'b1);
        check("t1_req_n1", 64'(route_req), 64'(R_NONE));
        send(40'($urandom), 1'b0, 1'b1);
        check("t1_req_n2", 64'(route_req), 64'(R_EAST));
        send(40'($urandom), 1'b1, 1'b1);
        tick();
        check("t1_no_valid_in_req", 64'(m_TVALID), 64'(1'b0));
        grant();
        wait_drain("t1_drain");
        check("t1_req_cleared", 64'(route_req), 64'(R_NONE));

        // Single flit to home.
        send(mk_head(3'd1, 2'd1), 1'b1, 1'b1);
        tick();
        check("t2_req_home", 64'(route_req), 64'(R_HOME));
        grant();
        wait_drain("t2_drain");
        check("t2_req_cleared", 64'(route_req), 64'(R_NONE));

        // Stray grant while idle, then back-to-back NORTH and WEST packets.
        grant();
        send(mk_head(3'd1, 2'd0), 1'b0, 1'b1);
        send(40'($urandom), 1'b1, 1'b1);
        send(mk_head(3'd0, 2'd2), 1'b0, 1'b1);
        send(40'($urandom), 1'b1, 1'b1);
        check("t3_req_north", 64'(route_req), 64'(R_NORTH));
        check("t3_no_valid_before_gnt", 64'(m_TVALID), 64'(1'b0));
        grant();
        wait_req("t3_req_west", R_WEST);
        check("t3_west_pending", 64'(exp_q.size()), 64'(2));
        grant();
        wait_drain("t3_drain");

        // Out-of-mesh destination x=5 is drained and dropped.
        drops0 = drops;
        bad = 1'b0;
        send(mk_head(3'd5, 2'd1), 1'b0, 1'b0);
        if (m_TVALID || route_req != R_NONE) bad = 1'b1;
        send(40'($urandom), 1'b1, 1'b0);
        for (int i = 0; i < 10; i++) begin
            if (m_TVALID || route_req != R_NONE) bad = 1'b1;
            tick();
        end
        check("t4_quiet", 64'(bad), 64'(1'b0));
        check("t4_drop_once", 64'(drops - drops0), 64'(1));

        // Backpressure: FIFO fills at 4, then all 6 flits leave in order.
        m_TREADY = 1'b0;
        send(mk_head(3'd2, 2'd1), 1'b0, 1'b1);
        tick();
        check("t5_req_east", 64'(route_req), 64'(R_EAST));
        grant();
        for (int i = 0; i < 3; i++) send(40'($urandom), 1'b0, 1'b1);
        check("t5_full", 64'(s_TREADY), 64'(1'b0));
        check("t5_valid_stalled", 64'(m_TVALID), 64'(1'b1));
        m_TREADY = 1'b1;
        tick();
        check("t5_ready_after_pop", 64'(s_TREADY), 64'(1'b1));
        send(40'($urandom), 1'b0, 1'b1);
        send(40'($urandom), 1'b1, 1'b1);
        wait_drain("t5_drain");

        // Reset after one of three beats, then a SOUTH packet.
        m_TREADY = 1'b0;
        send(mk_head(3'd3, 2'd1), 1'b0, 1'b1);
        send(40'($urandom), 1'b0, 1'b1);
        send(40'($urandom), 1'b1, 1'b1);
        grant();
        m_TREADY = 1'b1;
        tick();
        m_TREADY = 1'b0;
        check("t6_one_beat", 64'(exp_q.size()), 64'(2));
        rst_n = 1'b0;
        #1;
        check("t6_rst_req", 64'(route_req), 64'(R_NONE));
        check("t6_rst_valid", 64'(m_TVALID), 64'(1'b0));
        exp_q.delete();
        tick(); tick();
        rst_n = 1'b1;
        tick();
        m_TREADY = 1'b1;
        check("t6_empty_ready", 64'(s_TREADY), 64'(1'b1));
        tick(); tick();
        check("t6_empty_no_valid", 64'(m_TVALID), 64'(1'b0));
        check("t6_idle_req", 64'(route_req), 64'(R_NONE));
        send(mk_head(3'd1, 2'd2), 1'b1, 1'b1);
        tick();
        check("t6_req_south", 64'(route_req), 64'(R_SOUTH));
        grant();
        wait_drain("t6_drain");
        tick();
        check("total_beats", 64'(beats), 64'(16));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
